// File: rtl/op_handler_arbiter.sv
// ============================================================================
// op_handler_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Routes one op at a time to one of NUM_CH handler channels. The selected
//   channel's motor-control signals are registered onto a single master port.
//   Its position-update results are collected and released as one update
//   pulse when the channel reports done. An op may be aborted while it runs.
//   An out-of-range channel select is rejected with a one-cycle error pulse.
//
// Parameters:
//   NUM_CH   number of handler channels (2..8)
//   PULSE_W  width of each pulse count field
//   POS_W    width of each position field
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   op_valid        a new op is presented
//   op_sel          target channel index of the op
//   op_ready        high only in IDLE; the block accepts an op this cycle
//   abort           cancel the active op (only honoured in BUSY)
//   ch_pulse_num_x  per-channel X pulse counts, channel i at [i*PULSE_W +: PULSE_W]
//   ch_pulse_num_y  per-channel Y pulse counts, same packing
//   ch_servo_pos    per-channel servo position (1 = down)
//   ch_trigger      per-channel motor trigger
//   ch_new_x        per-channel updated X, channel i at [i*POS_W +: POS_W]
//   ch_new_y        per-channel updated Y, same packing
//   ch_update       per-channel position update strobe
//   ch_done         per-channel op-finished strobe
//   pulse_num_x/y   registered master pulse counts
//   servo_pos       registered master servo position
//   trigger         registered master motor trigger
//   new_x/new_y     registered master position update
//   update          one-cycle position update strobe
//   active_ch       latched channel index of the current/last op
//   sel_err         one-cycle pulse when an out-of-range op_sel is rejected
// ============================================================================
module op_handler_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int PULSE_W = 16,
    parameter int POS_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       op_valid,
    input  logic [2:0]                 op_sel,
    output logic                       op_ready,
    input  logic                       abort,
    input  logic [NUM_CH*PULSE_W-1:0]  ch_pulse_num_x,
    input  logic [NUM_CH*PULSE_W-1:0]  ch_pulse_num_y,
    input  logic [NUM_CH-1:0]          ch_servo_pos,
    input  logic [NUM_CH-1:0]          ch_trigger,
    input  logic [NUM_CH*POS_W-1:0]    ch_new_x,
    input  logic [NUM_CH*POS_W-1:0]    ch_new_y,
    input  logic [NUM_CH-1:0]          ch_update,
    input  logic [NUM_CH-1:0]          ch_done,
    output logic [PULSE_W-1:0]         pulse_num_x,
    output logic [PULSE_W-1:0]         pulse_num_y,
    output logic                       servo_pos,
    output logic                       trigger,
    output logic [POS_W-1:0]           new_x,
    output logic [POS_W-1:0]           new_y,
    output logic                       update,
    output logic [2:0]                 active_ch,
    output logic                       sel_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Channel count widened to 4 bits so op_sel can be compared without
    // mixing widths; op_sel values NUM_CH..7 are out of range.
    localparam logic [3:0] NUM_CH_U = 4'(NUM_CH);

    state_t state;
    state_t state_next;

    logic               op_sel_ok;
    logic               op_accept;

    logic [PULSE_W-1:0] sel_pulse_x;
    logic [PULSE_W-1:0] sel_pulse_y;
    logic               sel_servo;
    logic               sel_trigger;
    logic [POS_W-1:0]   sel_new_x;
    logic [POS_W-1:0]   sel_new_y;
    logic               sel_update;
    logic               sel_done;

    logic [POS_W-1:0]   hold_x;
    logic [POS_W-1:0]   hold_y;
    logic               upd_seen;

    assign op_sel_ok = ({1'b0, op_sel} < NUM_CH_U);
    assign op_accept = (state == IDLE) && op_valid && op_sel_ok;
    assign op_ready  = (state == IDLE);

    // Channel multiplexer. The latched active_ch picks one channel's signals.
    // Every other channel reads as zero, so idle channels cannot leak through.
    always_comb begin
        sel_pulse_x = '0;
        sel_pulse_y = '0;
        sel_servo   = 1'b0;
        sel_trigger = 1'b0;
        sel_new_x   = '0;
        sel_new_y   = '0;
        sel_update  = 1'b0;
        sel_done    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active_ch == 3'(i)) begin
                sel_pulse_x = ch_pulse_num_x[i*PULSE_W +: PULSE_W];
                sel_pulse_y = ch_pulse_num_y[i*PULSE_W +: PULSE_W];
                sel_servo   = ch_servo_pos[i];
                sel_trigger = ch_trigger[i];
                sel_new_x   = ch_new_x[i*POS_W +: POS_W];
                sel_new_y   = ch_new_y[i*POS_W +: POS_W];
                sel_update  = ch_update[i];
                sel_done    = ch_done[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort beats a same-cycle done, so an aborted op
    // never reaches DONE and never emits an update. DONE lasts exactly one
    // cycle, which is the cycle the update strobe is visible.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (op_accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sel_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // The motor master follows the active channel with one cycle of latency
    // while BUSY. It keeps its last values outside BUSY, except trigger,
    // which drops to zero as soon as the op ends (done or abort).
    // Position updates go to a holding register first. The master new_x/new_y
    // and the update strobe are loaded only on the done transition, so they
    // show during the single DONE cycle. A strobe arriving in that same cycle
    // is used directly, so it takes priority over the older held value.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_ch   <= 3'd0;
            pulse_num_x <= '0;
            pulse_num_y <= '0;
            servo_pos   <= 1'b0;
            trigger     <= 1'b0;
            new_x       <= '0;
            new_y       <= '0;
            update      <= 1'b0;
            sel_err     <= 1'b0;
            hold_x      <= '0;
            hold_y      <= '0;
            upd_seen    <= 1'b0;
        end else begin
            sel_err <= (state == IDLE) && op_valid && !op_sel_ok;
            update  <= 1'b0;
            trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_accept) begin
                        active_ch <= op_sel;
                        upd_seen  <= 1'b0;
                    end
                end
                BUSY: begin
                    pulse_num_x <= sel_pulse_x;
                    pulse_num_y <= sel_pulse_y;
                    servo_pos   <= sel_servo;
                    trigger     <= sel_trigger && !abort && !sel_done;
                    if (sel_update) begin
                        hold_x   <= sel_new_x;
                        hold_y   <= sel_new_y;
                        upd_seen <= 1'b1;
                    end
                    if (!abort && sel_done) begin
                        if (sel_update) begin
                            new_x  <= sel_new_x;
                            new_y  <= sel_new_y;
                            update <= 1'b1;
                        end else if (upd_seen) begin
                            new_x  <= hold_x;
                            new_y  <= hold_y;
                            update <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/op_handler_arbiter.md
OP_HANDLER_ARBITER -- requirements
Module: op_handler_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of handler channels (2..8).
REQ-002 SHALL have parameter PULSE_W, default 16, meaning the width of each pulse count field.
REQ-003 SHALL have parameter POS_W, default 16, meaning the width of each position field.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-006 SHALL have port op_valid, input, 1 bit, meaning a new op is presented.
REQ-007 SHALL have port op_sel, input, 3 bits, meaning the target channel index decoded from op cmd.
REQ-008 SHALL have port op_ready, output, 1 bit, meaning the block accepts an op this cycle.
REQ-009 SHALL have port abort, input, 1 bit, meaning cancel the active op.
REQ-010 SHALL have port ch_pulse_num_x, input, NUM_CH*PULSE_W bits, meaning per-channel X pulses; channel i occupies slice [i*PULSE_W +: PULSE_W].
REQ-011 SHALL have port ch_pulse_num_y, input, NUM_CH*PULSE_W bits, meaning per-channel Y pulses, packed as in REQ-010.
REQ-012 SHALL have port ch_servo_pos, input, NUM_CH bits, meaning per-channel servo position (1 = down).
REQ-013 SHALL have port ch_trigger, input, NUM_CH bits, meaning per-channel motor trigger.
REQ-014 SHALL have port ch_new_x, input, NUM_CH*POS_W bits, meaning per-channel updated X.
REQ-015 SHALL have port ch_new_y, input, NUM_CH*POS_W bits, meaning per-channel updated Y.
REQ-016 SHALL have port ch_update, input, NUM_CH bits, meaning per-channel position update strobe.
REQ-017 SHALL have port ch_done, input, NUM_CH bits, meaning the per-channel handler finished its op.
REQ-018 SHALL have port pulse_num_x, pulse_num_y, servo_pos and trigger as outputs, PULSE_W / PULSE_W / 1 / 1 bits, meaning the registered motors-control master.
REQ-019 SHALL have port new_x, new_y and update as outputs, POS_W / POS_W / 1 bits, meaning the registered position-update master.
REQ-020 SHALL have port active_ch, output, 3 bits, meaning the latched channel index.
REQ-021 SHALL have port sel_err, output, 1 bit, meaning an out-of-range op_sel was rejected.

Function
REQ-022 SHALL implement states IDLE, BUSY and DONE.
REQ-023 SHALL drive op_ready=1 only in IDLE.
REQ-024 SHALL, in IDLE with op_valid=1 and op_sel<NUM_CH, latch active_ch=op_sel, clear the upd_seen flag and go to BUSY next cycle.
REQ-025 SHALL, in IDLE with op_valid=1 and op_sel>=NUM_CH, pulse sel_err for exactly 1 cycle and remain in IDLE.
REQ-026 SHALL, in BUSY, register the pulse_num_x, pulse_num_y, servo_pos and trigger of channel active_ch every cycle, giving 1-cycle latency; inputs of unselected channels SHALL have no effect.
REQ-027 SHALL, in BUSY with ch_update[active_ch]=1, capture ch_new_x/ch_new_y into a holding register and set upd_seen; a later strobe overwrites the earlier capture.
REQ-028 SHALL, in BUSY with ch_done[active_ch]=1, go to DONE; a same-cycle update strobe SHALL be captured first.
REQ-029 SHALL, in DONE, drive update=1 for exactly 1 cycle with the held new_x/new_y if upd_seen=1 (update stays 0 otherwise), drive trigger=0, then go to IDLE.
REQ-030 SHALL, in BUSY with abort=1, go to IDLE, force trigger=0 next cycle and emit no update; abort SHALL win over a simultaneous ch_done.
REQ-031 SHALL ignore abort in IDLE and DONE.
REQ-032 SHALL, outside BUSY, force trigger=0 while pulse_num_x, pulse_num_y, servo_pos, new_x and new_y hold their last values.
REQ-033 SHALL ignore op_valid outside IDLE; no op is queued.

Reset
REQ-034 SHALL, with reset=1, go to IDLE and set active_ch=0, pulse_num_x/y=0, servo_pos=0 (up), trigger=0, new_x/y=0, update=0, sel_err=0 and upd_seen=0.
REQ-035 SHALL let reset override every other input, including mid-op in BUSY or DONE, with no update pulse emitted.

Verification
REQ-036 SHALL verify: NUM_CH=3; op_sel=1; ch1 x=2, y=2, servo=1, trig=1; ch1 update with (5,7), then done -> outputs 2/2/1/1 one cycle after BUSY entry, update=1 for one cycle with (5,7), op_ready returns.
REQ-037 SHALL verify: op_sel=3 with NUM_CH=3 -> sel_err pulses for 1 cycle, state stays IDLE, outputs unchanged.
REQ-038 SHALL verify: ch0 active while ch2 toggles trigger/update/done -> no output change, no DONE.
REQ-039 SHALL verify: abort and ch_done in the same BUSY cycle -> IDLE, trigger=0, update never asserted.
REQ-040 SHALL verify: ch_done without a prior update -> DONE, update stays 0, new_x/new_y hold their previous op's values.
REQ-041 SHALL verify: reset asserted in BUSY with trigger=1 -> all outputs at reset values next cycle, op_ready=1.
